cache_controller: RTL
=====================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter WIDTH, default 32: CPU and cache word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 10: word address width, split as tag[9:7], index[6:2], offset[1:0].
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 cpu_req  in  1  request strobe; sampled only in IDLE.
REQ-006 cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
REQ-007 cpu_addr  in  ADDR_WIDTH  word address; sampled with cpu_req.
REQ-008 cpu_wdata  in  WIDTH  write data; sampled with cpu_req.
REQ-009 cpu_rdata  out  WIDTH  read data; valid while cpu_ready=1 for a read.
REQ-010 cpu_ready  out  1  one-cycle completion pulse per request.
REQ-011 c_index/c_tag/c_offset  out  5/3/2  registered address fields driven to the cache array.
REQ-012 c_update  out  1  cache control; with c_refill selects the operation per REQ-019.
REQ-013 c_refill  out  1  cache control; see REQ-019.
REQ-014 c_wdata  out  WIDTH  registered cpu_wdata to the cache array.
REQ-015 c_wblock  out  4*WIDTH  captured memory block to the cache array.
REQ-016 c_hit / c_rdata  in  1 / WIDTH  cache hit and registered read word.
REQ-017 mem_rd / mem_wr  out  1 / 1  memory block-read / word-write requests, held until mem_ready.
REQ-018 mem_addr, mem_wdata, mem_rdata, mem_ready  out ADDR_WIDTH, out WIDTH, in 4*WIDTH, in 1  memory port; mem_addr offset bits forced to 0 for reads.

Function
REQ-019 Encoding {c_update,c_refill}: 00 idle, 11 read word, 10 fill block, 01 write word; no other combination driven.
REQ-020 States: IDLE, COMPARE, RD_WAIT, MEM_READ, FILL, MEM_WRITE, DONE.
REQ-021 IDLE: cpu_req=1 registers cpu_we/cpu_addr/cpu_wdata and moves to COMPARE; cpu_req=0 stays.
REQ-022 COMPARE, read, c_hit=1: drive 11 for one cycle -> RD_WAIT; RD_WAIT -> DONE with cpu_rdata latched from c_rdata.
REQ-023 COMPARE, read, c_hit=0: -> MEM_READ; mem_rd held until mem_ready=1, then mem_rdata captured into c_wblock -> FILL.
REQ-024 FILL: drive 10 for one cycle -> COMPARE; re-compare SHALL hit.
REQ-025 COMPARE, write, c_hit=1: drive 01 for one cycle (write-through) -> MEM_WRITE.
REQ-026 COMPARE, write, c_hit=0: no cache write (no-write-allocate) -> MEM_WRITE.
REQ-027 MEM_WRITE: mem_wr held with mem_addr=full address, mem_wdata=c_wdata until mem_ready=1 -> DONE.
REQ-028 DONE: cpu_ready=1 for exactly one cycle -> IDLE; cpu_req in DONE is ignored.
REQ-029 Read-hit latency: cpu_req to cpu_ready = 4 cycles; read miss = 6 cycles plus memory wait cycles.
REQ-030 mem_rd and mem_wr never both 1; mem_ready outside MEM_READ/MEM_WRITE is ignored.

Reset
REQ-031 reset=0 at a clock edge: state IDLE; cpu_ready, mem_rd, mem_wr, c_update, c_refill = 0; cpu_rdata, c_wblock, address/data registers = 0.
REQ-032 Reset mid-transaction abandons it with no cpu_ready pulse; mem_rd/mem_wr drop on that edge.

Structure
REQ-033 Shared package cache_pkg: state enum, {c_update,c_refill} encodings, tag/index/offset widths.
REQ-034 Single module, no sub-module; a testbench instantiates it with the cache array and a memory model.

Verification
REQ-035 Read 0x004 after reset, memory block 0x1 = {D,C,B,A}, mem_ready after 2 cycles -> mem_rd pulse, fill, cpu_rdata=A, cpu_ready once.
REQ-036 Re-read 0x005 -> hit, no mem_rd, cpu_rdata=B, cpu_ready 4 cycles after cpu_req.
REQ-037 Write 0x005 = 0xDEADBEEF (hit) -> {c_update,c_refill}=01 once, mem_wr with mem_addr=0x005; later read returns 0xDEADBEEF.
REQ-038 Write 0x3FC = 0x12345678 (miss) -> no cache write, mem_wr only; read 0x3FC then misses.
REQ-039 reset=0 during MEM_READ wait -> mem_rd=0 next edge, no cpu_ready, state IDLE.
REQ-040 cpu_req held high continuously -> requests served back-to-back with exactly one cpu_ready per request.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped cache controller: FSM states, cache-array
// operation encodings and the tag/index/offset split of a word address.
package cache_pkg;

    localparam int TAG_W    = 3;
    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 2;
    localparam int WORDS    = 1 << OFFSET_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_RD_WAIT,
        ST_MEM_READ,
        ST_FILL,
        ST_MEM_WRITE,
        ST_DONE
    } state_t;

    // Driven on {c_update, c_refill}
    typedef enum logic [1:0] {
        OP_IDLE       = 2'b00,
        OP_WRITE_WORD = 2'b01,
        OP_FILL_BLOCK = 2'b10,
        OP_READ_WORD  = 2'b11
    } cache_op_t;

endpackage

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate controller; read hit 4 cycles, miss 6 + memory cycles.
// The CPU is blocked until the cpu_ready pulse; memory requests are held until mem_ready.
module cache_controller
    import cache_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_WIDTH-1:0]  cpu_addr,
    input  logic [WIDTH-1:0]       cpu_wdata,
    output logic [WIDTH-1:0]       cpu_rdata,
    output logic                   cpu_ready,
    output logic [INDEX_W-1:0]     c_index,
    output logic [TAG_W-1:0]       c_tag,
    output logic [OFFSET_W-1:0]    c_offset,
    output logic                   c_update,
    output logic                   c_refill,
    output logic [WIDTH-1:0]       c_wdata,
    output logic [WORDS*WIDTH-1:0] c_wblock,
    input  logic                   c_hit,
    input  logic [WIDTH-1:0]       c_rdata,
    output logic                   mem_rd,
    output logic                   mem_wr,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [WIDTH-1:0]       mem_wdata,
    input  logic [WORDS*WIDTH-1:0] mem_rdata,
    input  logic                   mem_ready
);

    state_t                 state_q, state_d;
    cache_op_t              op_q, op_d;
    logic                   we_q, we_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic [INDEX_W-1:0]     index_q, index_d;
    logic [OFFSET_W-1:0]    offset_q, offset_d;
    logic [WIDTH-1:0]       wdata_q, wdata_d;
    logic [WORDS*WIDTH-1:0] wblock_q, wblock_d;
    logic [WIDTH-1:0]       rdata_q, rdata_d;
    logic                   ready_q, ready_d;
    logic                   mem_rd_q, mem_rd_d;
    logic                   mem_wr_q, mem_wr_d;

    always_comb begin
        state_d  = state_q;
        op_d     = OP_IDLE;
        we_d     = we_q;
        tag_d    = tag_q;
        index_d  = index_q;
        offset_d = offset_q;
        wdata_d  = wdata_q;
        wblock_d = wblock_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    we_d     = cpu_we;
                    tag_d    = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
                    index_d  = cpu_addr[OFFSET_W +: INDEX_W];
                    offset_d = cpu_addr[OFFSET_W-1:0];
                    wdata_d  = cpu_wdata;
                    state_d  = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (!we_q) begin
                    if (c_hit) begin
                        op_d    = OP_READ_WORD;
                        state_d = ST_RD_WAIT;
                    end else begin
                        mem_rd_d = 1'b1;
                        state_d  = ST_MEM_READ;
                    end
                end else begin
                    // Write-through: memory is always written; the cache only on a hit.
                    if (c_hit) begin
                        op_d = OP_WRITE_WORD;
                    end
                    mem_wr_d = 1'b1;
                    state_d  = ST_MEM_WRITE;
                end
            end
            ST_RD_WAIT: begin
                state_d = ST_DONE;
            end
            ST_MEM_READ: begin
                if (mem_ready) begin
                    wblock_d = mem_rdata;
                    mem_rd_d = 1'b0;
                    op_d     = OP_FILL_BLOCK;
                    state_d  = ST_FILL;
                end
            end
            ST_FILL: begin
                state_d = ST_COMPARE;
            end
            ST_MEM_WRITE: begin
                if (mem_ready) begin
                    mem_wr_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                // The array's registered read word is stable here after RD_WAIT.
                if (!we_q) begin
                    rdata_d = c_rdata;
                end
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_IDLE;
            we_q     <= 1'b0;
            tag_q    <= '0;
            index_q  <= '0;
            offset_q <= '0;
            wdata_q  <= '0;
            wblock_q <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            we_q     <= we_d;
            tag_q    <= tag_d;
            index_q  <= index_d;
            offset_q <= offset_d;
            wdata_q  <= wdata_d;
            wblock_q <= wblock_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
        end
    end

    assign {c_update, c_refill} = op_q;
    assign cpu_rdata = rdata_q;
    assign cpu_ready = ready_q;
    assign c_tag     = tag_q;
    assign c_index   = index_q;
    assign c_offset  = offset_q;
    assign c_wdata   = wdata_q;
    assign c_wblock  = wblock_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = wdata_q;
    // Block reads are aligned; word writes carry the full address.
    assign mem_addr  = {tag_q, index_q, (mem_rd_q ? {OFFSET_W{1'b0}} : offset_q)};

endmodule
